ips2l_uart_tx_arb_32bit: RTL and testbench
==========================================

IPS2L_UART_TX_ARB_32BIT -- requirements
Module: ips2l_uart_tx_arb_32bit

Interface
REQ-001 Parameter: TIMEOUT_CYC, default 1024, cycles allowed in SEND without tx_ack before the held word is dropped; legal range 2..65535.
REQ-002 Port: clk  in  1  single clock; all logic rising-edge.
REQ-003 Port: rst  in  1  asynchronous, active-high reset.
REQ-004 Port: src_req  in  3  per-source word-pending request; bit i = source i.
REQ-005 Port: src_data  in  96  source i word on [32*i+31:32*i]; stable while src_req[i]=1 and until src_ack[i].
REQ-006 Port: src_ack  out  3  one-cycle pulse; word of source i captured this cycle.
REQ-007 Port: tx_data  out  32  word presented to the UART TX FIFO write side.
REQ-008 Port: tx_req  out  1  tx_data valid; held until accepted.
REQ-009 Port: tx_ack  in  1  one-cycle accept from the TX FIFO side; meaningful only while tx_req=1.
REQ-010 Port: grant_id  out  2  source index of the word in tx_data (0..2).
REQ-011 Port: timeout_err  out  1  one-cycle pulse; held word dropped on timeout.
REQ-012 Port: word_cnt  out  16  count of words accepted by tx_ack.

Function
REQ-013 States: IDLE (tx_req=0), SEND (tx_req=1); no other states.
REQ-014 Arbitration: round-robin over pending src_req; search starts at (last_grant+1) mod 3; last_grant updates on every capture.
REQ-015 Capture (IDLE with any src_req, or SEND completing with any src_req): register selected src_data into tx_data, set grant_id, pulse src_ack[sel] in the same cycle, enter/stay SEND next cycle.
REQ-016 Latency: src_req rising in cycle N from IDLE -> src_ack in N, tx_req=1 with data in N+1.
REQ-017 Throughput: back-to-back capture on tx_ack allows one word per cycle; tx_req stays 1 with no bubble.
REQ-018 In SEND, tx_data and grant_id stay stable until tx_ack=1 or timeout.
REQ-019 SEND completion with no src_req pending -> IDLE next cycle, tx_req=0.
REQ-020 At most one src_ack bit high per cycle; no src_ack while in SEND without completion.
REQ-021 Timeout counter: cleared on every capture, increments each SEND cycle with tx_ack=0; when it reaches TIMEOUT_CYC-1 without tx_ack, word is dropped, timeout_err pulses that cycle, completion handled as REQ-015/REQ-019.
REQ-022 tx_ack and timeout in the same cycle: ack wins, timeout_err=0, word counted.
REQ-023 word_cnt increments by 1 per tx_ack in SEND; wraps 0xFFFF -> 0x0000; dropped words not counted.
REQ-024 tx_ack while in IDLE ignored: no count, no state change.
REQ-025 src_req deasserted by a source before grant: simply not considered; no error.

Reset
REQ-026 While rst=1: state IDLE, src_ack=0, tx_req=0, tx_data=0, grant_id=0, timeout_err=0, word_cnt=0, timeout counter=0, last_grant=2 (source 0 has first priority).
REQ-027 rst asserted mid-SEND: held word discarded, no src_ack or timeout_err pulse, outputs go to reset values asynchronously.
REQ-028 First arbitration after rst release happens on the first clk edge with rst=0.

Verification
REQ-029 Single source: src_req=3'b001, src_data[31:0]=0xA5A5_0001, tx_ack one cycle after tx_req -> src_ack=3'b001 in N, tx_data=0xA5A5_0001, grant_id=0 at N+1, word_cnt=1, IDLE after.
REQ-030 All three requesting continuously, tx_ack tied 1 -> grant_id sequence 0,1,2,0,1,2, tx_req constantly 1, word_cnt +1 per cycle.
REQ-031 TIMEOUT_CYC=4, tx_ack held 0 -> timeout_err pulses exactly 4 SEND cycles after tx_req rise, word_cnt unchanged, next pending source captured.
REQ-032 TIMEOUT_CYC=4, tx_ack=1 on the timeout cycle -> timeout_err=0, word_cnt increments.
REQ-033 word_cnt preloaded to 0xFFFF by 65535 accepted words, one more accepted -> word_cnt=0x0000.
REQ-034 rst pulsed during SEND with src_req=3'b110 -> all outputs zero; after release first grant goes to source 1 (priority restarts at 0, 0 not requesting).

Source files
------------

// File: rtl/ips2l_uart_tx_arb_32bit.sv
// ---------------------------------------------------------------------------
// ips2l_uart_tx_arb_32bit
//
// Round-robin arbiter that collects 32-bit words from three sources and
// presents them, one at a time, to the write side of a UART TX FIFO.
// A word captured from a source is held on tx_data with tx_req=1 until the
// FIFO side accepts it with tx_ack. If no accept arrives within TIMEOUT_CYC
// SEND cycles, the word is dropped and timeout_err pulses. When a word
// completes, the next pending source is captured in the same cycle, so a
// continuously accepting FIFO receives one word per clock.
//
// Parameters
//   TIMEOUT_CYC  SEND cycles allowed without tx_ack before the word is
//                dropped (2..65535)
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous, active-high reset
//   src_req      [2:0]  per-source word-pending request
//   src_data     [95:0] source i word on [32*i+31:32*i]
//   src_ack      [2:0]  one-cycle pulse: word of source i captured this cycle
//   tx_data      [31:0] word presented to the TX FIFO
//   tx_req       tx_data valid, held until accepted or dropped
//   tx_ack       one-cycle accept from the TX FIFO (used only in SEND)
//   grant_id     [1:0]  source index of the word on tx_data
//   timeout_err  one-cycle pulse: held word dropped on timeout
//   word_cnt     [15:0] wrapping count of accepted words
// ---------------------------------------------------------------------------
module ips2l_uart_tx_arb_32bit #(
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  src_req,
    input  logic [95:0] src_data,
    output logic [2:0]  src_ack,
    output logic [31:0] tx_data,
    output logic        tx_req,
    input  logic        tx_ack,
    output logic [1:0]  grant_id,
    output logic        timeout_err,
    output logic [15:0] word_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // Counter value at which the held word is dropped.
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);

    state_t      state;
    state_t      next_state;
    logic [1:0]  last_grant;
    logic [15:0] tmo_cnt;

    logic [1:0]  sel;
    logic        sel_valid;
    logic [1:0]  idx;
    logic [31:0] sel_data;

    logic        ack_hit;
    logic        timeout_hit;
    logic        complete;
    logic        capture;

    // Source index following i in the 0 -> 1 -> 2 -> 0 rotation.
    function automatic logic [1:0] next_idx(input logic [1:0] i);
        return (i >= 2'd2) ? 2'd0 : i + 2'd1;
    endfunction

    // -----------------------------------------------------------------------
    // Round-robin selection: first pending source after last_grant.
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every combinational output gets a default before any
        // conditional assignment, otherwise the tool infers a latch.
        sel       = 2'd0;
        sel_valid = 1'b0;
        idx       = next_idx(last_grant);
        for (int k = 0; k < 3; k++) begin
            if (!sel_valid && src_req[idx]) begin
                sel       = idx;
                sel_valid = 1'b1;
            end
            idx = next_idx(idx);
        end
    end

    always_comb begin
        sel_data = src_data[31:0];
        case (sel)
            2'd1:    sel_data = src_data[63:32];
            2'd2:    sel_data = src_data[95:64];
            default: sel_data = src_data[31:0];
        endcase
    end

    // A held word completes either by accept or by timeout; accept wins
    // when both fall in the same cycle.
    assign ack_hit     = (state == SEND) && tx_ack;
    assign timeout_hit = (state == SEND) && !tx_ack && (tmo_cnt == TMO_LAST);
    assign complete    = ack_hit || timeout_hit;
    // Gated by rst so that no src_ack can escape while reset is held.
    assign capture     = !rst && sel_valid && ((state == IDLE) || complete);

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples its inputs from the same clock edge.
            state <= next_state;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (capture) next_state = SEND;
            SEND: if (complete && !capture) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM: outputs
    // -----------------------------------------------------------------------
    always_comb begin
        src_ack     = 3'b000;
        tx_req      = (state == SEND);
        timeout_err = timeout_hit;
        if (capture) begin
            src_ack = 3'b001 << sel;
        end
    end

    // -----------------------------------------------------------------------
    // Datapath: held word, grant bookkeeping, timeout and word counters
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_data    <= 32'd0;
            grant_id   <= 2'd0;
            last_grant <= 2'd2;       // source 0 has first priority
        end else if (capture) begin
            tx_data    <= sel_data;
            grant_id   <= sel;
            last_grant <= sel;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt <= 16'd0;
        end else if (capture) begin
            tmo_cnt <= 16'd0;
        end else if ((state == SEND) && !tx_ack) begin
            // Stale value left after a drop to IDLE is cleared by the next
            // capture before it is looked at again.
            tmo_cnt <= tmo_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_cnt <= 16'd0;
        end else if (ack_hit) begin
            word_cnt <= word_cnt + 16'd1;   // wraps 0xFFFF -> 0x0000
        end
    end

endmodule

// File: tb/tb_ips2l_uart_tx_arb_32bit.sv
module tb_ips2l_uart_tx_arb_32bit;

    logic        clk;
    logic        rst;
    logic [2:0]  src_req;
    logic [95:0] src_data;
    logic [2:0]  src_ack;
    logic [31:0] tx_data;
    logic        tx_req;
    logic        tx_ack;
    logic [1:0]  grant_id;
    logic        timeout_err;
    logic [15:0] word_cnt;

    typedef struct {
        logic [1:0]  id;
        logic [31:0] data;
    } exp_t;

    exp_t sb_q[$];
    exp_t sb_e;
    bit   sb_en;
    int   n_chk;
    int   n_pass;

    ips2l_uart_tx_arb_32bit #(.TIMEOUT_CYC(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .src_req     (src_req),
        .src_data    (src_data),
        .src_ack     (src_ack),
        .tx_data     (tx_data),
        .tx_req      (tx_req),
        .tx_ack      (tx_ack),
        .grant_id    (grant_id),
        .timeout_err (timeout_err),
        .word_cnt    (word_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: every accepted word must match the oldest expected entry.
    always @(negedge clk) begin
        if (sb_en && !rst && tx_req && tx_ack) begin
            n_chk++;
            if (sb_q.size() == 0) begin
                $display("FAIL sb_accept: got id %0d data %h, expected no word", grant_id, tx_data);
            end else begin
                sb_e = sb_q.pop_front();
                if ({grant_id, tx_data} !== {sb_e.id, sb_e.data})
                    $display("FAIL sb_accept: got id %0d data %h, expected id %0d data %h",
                             grant_id, tx_data, sb_e.id, sb_e.data);
                else
                    n_pass++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        step();
        rst = 1'b1; src_req = 3'b000; tx_ack = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; tx_ack = 1'b0;
        src_data = {32'h0, 32'h0, 32'hDEAD_BEEF};
        src_req  = 3'b001;
        @(negedge clk);
        n_chk++;
        if ({src_ack, tx_req, tx_data, grant_id, timeout_err, word_cnt} !== 55'd0)
            $display("FAIL reset_outputs: got ack %b req %b data %h id %0d tmo %b cnt %h, expected all zero",
                     src_ack, tx_req, tx_data, grant_id, timeout_err, word_cnt);
        else n_pass++;
        step();
        src_req = 3'b000;
        step();
        rst = 1'b0;
    endtask

    task automatic test_single();
        step();
        src_data[31:0] = 32'hA5A5_0001; src_req = 3'b001;
        sb_q.push_back('{2'd0, 32'hA5A5_0001});
        @(negedge clk);
        n_chk++;
        if ({src_ack, tx_req} !== 4'b0010)
            $display("FAIL single_capture: got ack %b req %b, expected ack 001 req 0", src_ack, tx_req);
        else n_pass++;
        step();
        src_req = 3'b000;
        @(negedge clk);
        n_chk++;
        if ({src_ack, tx_req, grant_id, tx_data} !== {3'b000, 1'b1, 2'd0, 32'hA5A5_0001})
            $display("FAIL single_present: got ack %b req %b id %0d data %h, expected 000 1 0 a5a50001",
                     src_ack, tx_req, grant_id, tx_data);
        else n_pass++;
        step();
        tx_ack = 1'b1;
        @(negedge clk);
        n_chk++;
        if (word_cnt !== 16'd0)
            $display("FAIL single_cnt_before: got %h expected 0000", word_cnt);
        else n_pass++;
        step();
        tx_ack = 1'b0;
        @(negedge clk);
        n_chk++;
        if ({tx_req, word_cnt} !== {1'b0, 16'd1})
            $display("FAIL single_done: got req %b cnt %h, expected req 0 cnt 0001", tx_req, word_cnt);
        else n_pass++;
    endtask

    task automatic test_idle_ack();
        step();
        src_req = 3'b000; tx_ack = 1'b1;
        step();
        step();
        tx_ack = 1'b0;
        @(negedge clk);
        n_chk++;
        if ({src_ack, tx_req, word_cnt} !== {3'b000, 1'b0, 16'd1})
            $display("FAIL idle_ack: got ack %b req %b cnt %h, expected 000 0 0001", src_ack, tx_req, word_cnt);
        else n_pass++;
    endtask

    task automatic test_round_robin();
        logic [2:0] exp_ack;
        reset_dut();
        step();
        src_data = {32'hC0DE_0002, 32'hC0DE_0001, 32'hC0DE_0000};
        src_req  = 3'b111; tx_ack = 1'b1;
        for (int k = 0; k < 7; k++) begin
            if (k != 0) step();
            sb_q.push_back('{2'(k % 3), 32'hC0DE_0000 + 32'(k % 3)});
            exp_ack = 3'b001 << (k % 3);
            @(negedge clk);
            n_chk++;
            if (src_ack !== exp_ack)
                $display("FAIL rr_ack_%0d: got %b expected %b", k, src_ack, exp_ack);
            else n_pass++;
            if (k != 0) begin
                n_chk++;
                if ({tx_req, word_cnt} !== {1'b1, 16'(k - 1)})
                    $display("FAIL rr_stream_%0d: got req %b cnt %h, expected req 1 cnt %h",
                             k, tx_req, word_cnt, 16'(k - 1));
                else n_pass++;
            end
        end
        step();
        src_req = 3'b000;
        @(negedge clk);
        n_chk++;
        if ({src_ack, tx_req, word_cnt} !== {3'b000, 1'b1, 16'd6})
            $display("FAIL rr_last: got ack %b req %b cnt %h, expected 000 1 0006", src_ack, tx_req, word_cnt);
        else n_pass++;
        step();
        tx_ack = 1'b0;
        @(negedge clk);
        n_chk++;
        if ({tx_req, word_cnt} !== {1'b0, 16'd7})
            $display("FAIL rr_end: got req %b cnt %h, expected req 0 cnt 0007", tx_req, word_cnt);
        else n_pass++;
    endtask

    task automatic test_timeout();
        reset_dut();
        step();
        src_data = {32'h0, 32'h7100_0001, 32'h7100_0000};
        src_req  = 3'b011; tx_ack = 1'b0;
        @(negedge clk);
        n_chk++;
        if (src_ack !== 3'b001)
            $display("FAIL tmo_capture: got %b expected 001", src_ack);
        else n_pass++;
        // Source 0 word is expected to be dropped; only source 1 is pushed.
        sb_q.push_back('{2'd1, 32'h7100_0001});
        step();
        src_req = 3'b010;
        for (int c = 1; c <= 4; c++) begin
            if (c != 1) step();
            @(negedge clk);
            n_chk++;
            if ({tx_req, grant_id, timeout_err, src_ack, word_cnt} !==
                {1'b1, 2'd0, (c == 4), ((c == 4) ? 3'b010 : 3'b000), 16'd0})
                $display("FAIL tmo_cycle_%0d: got req %b id %0d tmo %b ack %b cnt %h, expected 1 0 %b %b 0000",
                         c, tx_req, grant_id, timeout_err, src_ack, word_cnt,
                         (c == 4), ((c == 4) ? 3'b010 : 3'b000));
            else n_pass++;
        end
        step();
        src_req = 3'b000;
        @(negedge clk);
        n_chk++;
        if ({tx_req, grant_id, tx_data, timeout_err} !== {1'b1, 2'd1, 32'h7100_0001, 1'b0})
            $display("FAIL tmo_next: got req %b id %0d data %h tmo %b, expected 1 1 71000001 0",
                     tx_req, grant_id, tx_data, timeout_err);
        else n_pass++;
        step();
        step();
        step();
        tx_ack = 1'b1;
        @(negedge clk);
        n_chk++;
        if ({tx_req, timeout_err} !== 2'b10)
            $display("FAIL tmo_ack_wins: got req %b tmo %b, expected req 1 tmo 0", tx_req, timeout_err);
        else n_pass++;
        step();
        tx_ack = 1'b0;
        @(negedge clk);
        n_chk++;
        if ({tx_req, word_cnt} !== {1'b0, 16'd1})
            $display("FAIL tmo_count: got req %b cnt %h, expected req 0 cnt 0001", tx_req, word_cnt);
        else n_pass++;
    endtask

    task automatic test_withdraw();
        step();
        src_data[31:0] = 32'h5EED_0000; src_req = 3'b001;
        sb_q.push_back('{2'd0, 32'h5EED_0000});
        @(negedge clk);
        n_chk++;
        if (src_ack !== 3'b001)
            $display("FAIL wd_capture: got %b expected 001", src_ack);
        else n_pass++;
        step();
        src_req = 3'b010;
        @(negedge clk);
        n_chk++;
        if ({src_ack, tx_req} !== 4'b0001)
            $display("FAIL wd_hold: got ack %b req %b, expected ack 000 req 1", src_ack, tx_req);
        else n_pass++;
        step();
        src_req = 3'b000; tx_ack = 1'b1;
        @(negedge clk);
        n_chk++;
        if (src_ack !== 3'b000)
            $display("FAIL wd_complete: got ack %b expected 000", src_ack);
        else n_pass++;
        step();
        tx_ack = 1'b0;
        @(negedge clk);
        n_chk++;
        if ({src_ack, tx_req, word_cnt} !== {3'b000, 1'b0, 16'd2})
            $display("FAIL wd_end: got ack %b req %b cnt %h, expected 000 0 0002", src_ack, tx_req, word_cnt);
        else n_pass++;
    endtask

    task automatic test_reset_mid_send();
        step();
        src_data = {32'h8800_0002, 32'h8800_0001, 32'h0};
        src_req  = 3'b110;
        @(negedge clk);
        n_chk++;
        if (src_ack !== 3'b010)
            $display("FAIL rms_capture: got %b expected 010", src_ack);
        else n_pass++;
        step();
        @(negedge clk);
        n_chk++;
        if ({tx_req, grant_id} !== {1'b1, 2'd1})
            $display("FAIL rms_send: got req %b id %0d, expected 1 1", tx_req, grant_id);
        else n_pass++;
        #1;
        rst = 1'b1;
        #1;
        n_chk++;
        if ({src_ack, tx_req, tx_data, grant_id, timeout_err, word_cnt} !== 55'd0)
            $display("FAIL rms_async: got ack %b req %b data %h id %0d tmo %b cnt %h, expected all zero",
                     src_ack, tx_req, tx_data, grant_id, timeout_err, word_cnt);
        else n_pass++;
        step();
        @(negedge clk);
        n_chk++;
        if ({src_ack, tx_req} !== 4'b0000)
            $display("FAIL rms_held: got ack %b req %b, expected 000 0", src_ack, tx_req);
        else n_pass++;
        step();
        rst = 1'b0;
        sb_q.push_back('{2'd1, 32'h8800_0001});
        @(negedge clk);
        n_chk++;
        if (src_ack !== 3'b010)
            $display("FAIL rms_first_grant: got %b expected 010", src_ack);
        else n_pass++;
        step();
        src_req = 3'b000; tx_ack = 1'b1;
        @(negedge clk);
        step();
        tx_ack = 1'b0;
        @(negedge clk);
        n_chk++;
        if ({tx_req, word_cnt} !== {1'b0, 16'd1})
            $display("FAIL rms_end: got req %b cnt %h, expected req 0 cnt 0001", tx_req, word_cnt);
        else n_pass++;
    endtask

    task automatic test_wrap();
        reset_dut();
        sb_en = 1'b0;
        step();
        src_data[31:0] = 32'h0000_0F0F; src_req = 3'b001; tx_ack = 1'b1;
        for (int k = 1; k <= 65536; k++) begin
            step();
            if (k == 65536) src_req = 3'b000;
            if (k == 256 || k == 65536) begin
                @(negedge clk);
                n_chk++;
                if (word_cnt !== 16'(k - 1))
                    $display("FAIL wrap_cnt_%0d: got %h expected %h", k, word_cnt, 16'(k - 1));
                else n_pass++;
            end
        end
        step();
        tx_ack = 1'b0;
        @(negedge clk);
        n_chk++;
        if ({tx_req, word_cnt} !== {1'b0, 16'd0})
            $display("FAIL wrap_zero: got req %b cnt %h, expected req 0 cnt 0000", tx_req, word_cnt);
        else n_pass++;
        sb_en = 1'b1;
    endtask

    initial begin
        n_chk   = 0;
        n_pass  = 0;
        sb_en   = 1'b1;
        rst     = 1'b1;
        src_req = 3'b000;
        src_data = 96'd0;
        tx_ack  = 1'b0;

        test_reset();
        test_single();
        test_idle_ack();
        test_round_robin();
        test_timeout();
        test_withdraw();
        test_reset_mid_send();
        test_wrap();

        n_chk++;
        if (sb_q.size() != 0)
            $display("FAIL sb_leftover: got %0d words never accepted, expected 0", sb_q.size());
        else n_pass++;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
